// File: rtl/text_engine.sv
// text_engine: turns a screen byte request into a font column byte by looking up
// the character at that text cell and then the matching glyph column.
module text_engine #(
  parameter int FIRST_CHAR = 32,
  parameter int LAST_CHAR  = 126
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pixel_req,
  input  logic [9:0]  pixel_address,
  input  logic [3:0]  invert_rows,
  output logic [5:0]  char_address,
  input  logic [7:0]  char_byte,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [7:0]  pixel_data,
  output logic        pixel_valid,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, CHAR_WAIT, CHAR_LATCH, FONT_WAIT, FONT_LATCH} state_t;
  localparam logic [7:0] firstChar = 8'(FIRST_CHAR);
  localparam logic [7:0] lastChar  = 8'(LAST_CHAR);
  state_t state, nextState;
  logic [1:0] textRow;
  logic half, blank, inRange;
  logic [2:0] colInChar;
  logic [10:0] glyphAddr;
  logic [7:0] fontByte;
  assign inRange = char_byte >= firstChar && char_byte <= lastChar;
  // Each glyph occupies 16 bytes: top half columns 0-7, bottom half 8-15.
  assign glyphAddr = ({3'b000, char_byte - firstChar} << 4) + 11'({half, colInChar});
  assign fontByte = blank ? 8'h00 : font_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nextState;
  always_comb
    nextState = state == IDLE       ? (pixel_req ? CHAR_WAIT : IDLE) :
                state == CHAR_WAIT  ? CHAR_LATCH :
                state == CHAR_LATCH ? FONT_WAIT :
                state == FONT_WAIT  ? FONT_LATCH : IDLE;
  always_comb busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      textRow <= '0;
      half <= 1'b0;
      colInChar <= '0;
      blank <= 1'b0;
      char_address <= '0;
      font_addr <= '0;
      pixel_data <= '0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_valid <= state == FONT_LATCH;
      if (state == IDLE && pixel_req) begin
        textRow <= pixel_address[9:8];
        half <= pixel_address[7];
        colInChar <= pixel_address[2:0];
        char_address <= {pixel_address[9:8], pixel_address[6:3]};
      end
      if (state == CHAR_LATCH) begin
        blank <= !inRange;
        font_addr <= inRange ? glyphAddr : '0;
      end
      if (state == FONT_LATCH)
        pixel_data <= invert_rows[textRow] ? ~fontByte : fontByte;
    end
endmodule

// File: tb/tb_text_engine.sv
// tb_text_engine: directed checks of text_engine against registered char/font memory models.
module tb_text_engine;
  logic clk = 1'b0;
  logic rst_n, pixel_req, pixel_valid, busy;
  logic [9:0] pixel_address;
  logic [3:0] invert_rows;
  logic [5:0] char_address;
  logic [7:0] char_byte, font_data, pixel_data;
  logic [10:0] font_addr;
  logic [7:0] charRam [64];
  logic [7:0] fontRam [2048];
  int nChecks = 0, nFail = 0, lat, pulses;
  logic midBusy, prevBusy;
  logic [11:0] acceptMask;

  text_engine dut (
    .clk(clk), .rst_n(rst_n), .pixel_req(pixel_req), .pixel_address(pixel_address),
    .invert_rows(invert_rows), .char_address(char_address), .char_byte(char_byte),
    .font_addr(font_addr), .font_data(font_data), .pixel_data(pixel_data),
    .pixel_valid(pixel_valid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    char_byte <= charRam[char_address];
    font_data <= fontRam[font_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts on a negedge; returns on the negedge where pixel_valid is seen (lat = edges after accept).
  task automatic xact(input logic [9:0] addr, output int l, output logic b);
    pixel_req = 1'b1;
    pixel_address = addr;
    @(negedge clk);
    b = busy;
    pixel_req = 1'b0;
    pixel_address = ~addr;
    l = 0;
    for (int i = 1; i <= 8 && l == 0; i++) begin
      @(negedge clk);
      if (pixel_valid) l = i;
    end
  endtask

  initial begin
    rst_n = 1'b0; pixel_req = 1'b0; pixel_address = '0; invert_rows = '0;
    for (int i = 0; i < 64; i++) charRam[i] = 8'h20;
    for (int i = 0; i < 2048; i++) fontRam[i] = 8'(i) ^ 8'h5A;
    fontRam[0] = 8'hAA;
    charRam[0] = 8'd65;  fontRam[528] = 8'h7C;
    charRam[6'h11] = 8'd66; fontRam[555] = 8'h96;
    charRam[1] = 8'h0A;
    charRam[2] = 8'h7F;
    charRam[16] = 8'd67; fontRam[560] = 8'h3C;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(pixel_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_data", 32'(pixel_data), 0);
    chk("rst_char_addr", 32'(char_address), 0);
    chk("rst_font_addr", 32'(font_addr), 0);
    rst_n = 1'b1;

    xact(10'h000, lat, midBusy);
    chk("a_busy", 32'(midBusy), 1);
    chk("a_latency", lat, 4);
    chk("a_char_addr", 32'(char_address), 32'h00);
    chk("a_font_addr", 32'(font_addr), 528);
    chk("a_data", 32'(pixel_data), 32'h7C);
    chk("a_idle", 32'(busy), 0);
    @(negedge clk);
    chk("a_pulse_end", 32'(pixel_valid), 0);
    chk("a_data_hold", 32'(pixel_data), 32'h7C);

    xact(10'h18B, lat, midBusy);
    chk("b_latency", lat, 4);
    chk("b_char_addr", 32'(char_address), 32'h11);
    chk("b_font_addr", 32'(font_addr), 555);
    chk("b_data", 32'(pixel_data), 32'h96);
    @(negedge clk);

    xact(10'h010, lat, midBusy);
    chk("del_font_addr", 32'(font_addr), 0);
    chk("del_data", 32'(pixel_data), 32'h00);
    @(negedge clk);
    xact(10'h008, lat, midBusy);
    chk("lf_char_addr", 32'(char_address), 32'h01);
    chk("lf_font_addr", 32'(font_addr), 0);
    chk("lf_data", 32'(pixel_data), 32'h00);
    @(negedge clk);
    invert_rows = 4'b0001;
    xact(10'h010, lat, midBusy);
    chk("blank_inv_data", 32'(pixel_data), 32'hFF);
    @(negedge clk);
    xact(10'h000, lat, midBusy);
    chk("a_inv_data", 32'(pixel_data), 32'h83);
    @(negedge clk);
    invert_rows = 4'b0010;
    xact(10'h100, lat, midBusy);
    chk("row1_font_addr", 32'(font_addr), 560);
    chk("row1_inv_data", 32'(pixel_data), 32'hC3);
    @(negedge clk);

    invert_rows = 4'b0000;
    pixel_req = 1'b1;
    pixel_address = 10'h000;
    prevBusy = 1'b0;
    acceptMask = '0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      acceptMask[k] = busy && !prevBusy;
      prevBusy = busy;
      if (pixel_valid) pulses++;
    end
    pixel_req = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (pixel_valid) pulses++;
    end
    chk("tput_accepts", 32'(acceptMask), 32'h421);
    chk("tput_pulses", pulses, 3);
    chk("tput_data", 32'(pixel_data), 32'h7C);

    charRam[0] = 8'd66;
    pixel_req = 1'b1;
    pixel_address = 10'h000;
    @(negedge clk);
    pixel_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_font_addr", 32'(font_addr), 544);
    #1 rst_n = 1'b0;
    #1;
    chk("async_data", 32'(pixel_data), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_font_addr", 32'(font_addr), 0);
    chk("async_valid", 32'(pixel_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (pixel_valid) pulses++;
    end
    chk("abandoned_pulses", pulses, 0);
    xact(10'h18B, lat, midBusy);
    chk("post_rst_latency", lat, 4);
    chk("post_rst_data", 32'(pixel_data), 32'h96);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule

// File: doc/text_engine.md
TEXT_ENGINE -- requirements
Module: text_engine

Interface
REQ-001 Parameter FIRST_CHAR, default 32, lowest ASCII code present in font memory.
REQ-002 Parameter LAST_CHAR, default 126, highest ASCII code present in font memory.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 pixel_req  in  1  screen requests one display byte; sampled only in IDLE.
REQ-006 pixel_address  in  10  requested byte: [9:7] page 0-7, [6:0] column 0-127.
REQ-007 invert_rows  in  4  per text row; bit r set inverts all bytes of row r.
REQ-008 char_address  out  6  to row generators: [5:4] text row 0-3, [3:0] char index 0-15.
REQ-009 char_byte  in  8  ASCII char from selected row generator; valid exactly 1 cycle after char_address changes (row generators are registered).
REQ-010 font_addr  out  11  font memory byte address.
REQ-011 font_data  in  8  font byte; valid 1 cycle after font_addr (registered memory).
REQ-012 pixel_data  out  8  display byte, vertical column, LSB = top pixel.
REQ-013 pixel_valid  out  1  one-cycle pulse: pixel_data updated.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 Address decode, latched at the accepting edge: text row = page[2:1], half = page[0], char col = column[6:3], col-in-char = column[2:0].
REQ-016 FSM states IDLE, CHAR_WAIT, CHAR_LATCH, FONT_WAIT, FONT_LATCH; one state per cycle, no stalls.
REQ-017 IDLE: pixel_req=1 -> latch decoded fields, drive char_address={text row, char col}, go CHAR_WAIT; else remain.
REQ-018 CHAR_WAIT -> CHAR_LATCH unconditionally.
REQ-019 CHAR_LATCH: sample char_byte; if FIRST_CHAR <= char_byte <= LAST_CHAR, font_addr = ((char_byte-FIRST_CHAR)<<4) + (half<<3) + col-in-char, computed 11 bits wide, no truncation for default parameters; else font_addr=0 and set internal blank flag; go FONT_WAIT.
REQ-020 FONT_WAIT -> FONT_LATCH unconditionally.
REQ-021 FONT_LATCH: pixel_data = blank ? 8'h00 : font_data, then XOR 8'hFF if invert_rows[text row] (sampled this cycle); pixel_valid=1 for this one cycle; go IDLE.
REQ-022 Latency: pixel_req high at edge N -> pixel_valid high during the cycle after edge N+4; throughput one byte per 5 cycles.
REQ-023 pixel_req while busy=1 is ignored, not queued; pixel_address changes while busy have no effect.
REQ-024 pixel_data holds its value between pulses; pixel_valid=0 outside FONT_LATCH.
REQ-025 Blank chars with invert set produce 8'hFF.
REQ-026 char_address and font_addr hold their last value until the next update.

Reset
REQ-027 rst_n=0 forces immediately, regardless of clk: state IDLE, pixel_data=8'h00, pixel_valid=0, busy=0, char_address=0, font_addr=0, blank flag=0, latched fields=0.
REQ-028 Reset mid-transaction abandons it; no pixel_valid pulse for the abandoned request.
REQ-029 First request is accepted on the first posedge with rst_n=1 and pixel_req=1.

Verification
REQ-030 Address 10'h000, char_byte 'A' (65), font_data 8'h7C -> char_address 0, font_addr 528, pixel_data 8'h7C, pixel_valid 4 cycles after accept.
REQ-031 Address 10'h18B (page 3, col 11), char 'B' (66) -> char_address 6'h11, font_addr 555.
REQ-032 char_byte 8'h0A, then 8'h7F, font_data 8'hAA -> font_addr 0, pixel_data 8'h00; same with invert_rows=4'b0001 on row 0 -> 8'hFF.
REQ-033 invert_rows=4'b0010, address 10'h100 (row 1), font_data 8'h3C -> pixel_data 8'hC3.
REQ-034 pixel_req held high for 12 cycles -> accepts at cycles 0, 5, 10, exactly one pulse per accept.
REQ-035 rst_n low during FONT_WAIT -> outputs cleared asynchronously, no pulse; next request completes normally.
